// File: rtl/ii_sched_pkg.sv
// Shared state encoding, eot bit positions and window-count helpers for the
// integral-image window scheduler.
package ii_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int EOT_ROW = 0;
  localparam int EOT_WIN = 1;

  function automatic int wins_per_row(input int img_w, input int fw, input int step);
    return (img_w - fw) / step + 1;
  endfunction

  function automatic int wins_per_col(input int img_h, input int fw, input int step);
    return (img_h - fw) / step + 1;
  endfunction

endpackage

// File: rtl/pix_skid.sv
// Two-entry valid/ready skid FIFO; a push is visible at the head the next cycle.
// No input ready: the writer throttles on occ. Head is held while out_vld && !out_rdy.
module pix_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d, wr_idx;
  logic         pop;

  always_comb begin
    pop    = (cnt_q != 2'd0) && out_rdy;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop) ent0_d = ent1_q;
    // Slot the new word lands in, after this cycle's pop has shifted the queue.
    wr_idx = cnt_q - 2'(pop);
    if (in_vld) begin
      if (wr_idx == 2'd0) ent0_d = in_dat;
      else                ent1_d = in_dat;
    end
    cnt_d = cnt_q - 2'(pop) + 2'(in_vld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = ent0_q;
  assign occ     = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(in_vld && (cnt_q == 2'd2) && !out_rdy));

endmodule

// File: rtl/ii_win_sched.sv
// Window scan scheduler: reads each FEATURE_WIDTH^2 window row-major from pixel RAM into a
// valid/ready pixel stream; first pixel 2 cycles after FETCH, 1 px/cycle; reads throttle on skid space.
// Optional II_WIN_SCHED_PERF_CNT_EN adds saturating stall_cnt / win_cnt outputs.
module ii_win_sched
  import ii_sched_pkg::*;
#(
  parameter int W_DATA        = 8,
  parameter int IMG_W         = 48,
  parameter int IMG_H         = 48,
  parameter int FEATURE_WIDTH = 24,
  parameter int STEP          = 1,
  parameter int ADDR_W        = $clog2(IMG_W*IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [W_DATA-1:0]        mem_rd_data,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [W_DATA-1:0]        dout_data,
  output logic [1:0]               dout_eot,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
  input  logic                     win_ack
`ifdef II_WIN_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [15:0]              win_cnt
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = (FEATURE_WIDTH > 1) ? $clog2(FEATURE_WIDTH) : 1;

  if (FEATURE_WIDTH > IMG_W || FEATURE_WIDTH > IMG_H || STEP < 1) begin : g_cfg_err
    $error("ii_win_sched: window must fit the image and STEP must be >= 1");
  end

  state_e            state_q, state_d;
  logic [XW-1:0]     win_x_q, win_x_d;
  logic [YW-1:0]     win_y_q, win_y_d;
  logic [ADDR_W-1:0] win_row_q, win_row_d;   // win_y * IMG_W
  logic [ADDR_W-1:0] row_base_q, row_base_d; // (win_y + r) * IMG_W + win_x
  logic [CW-1:0]     r_q, r_d, c_q, c_d;
  logic              infl_q;
  logic [1:0]        eot_infl_q, rd_eot;
  logic [1:0]        skid_occ;
  logic [2:0]        pend;
  logic              pop;

  always_comb begin
    state_d    = state_q;
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    win_row_d  = win_row_q;
    row_base_d = row_base_q;
    r_d        = r_q;
    c_d        = c_q;

    pop       = dout_valid && dout_ready;
    // Words already owed to the skid once this cycle's pop leaves it.
    pend      = {1'b0, skid_occ} + {2'b00, infl_q} - {2'b00, pop};
    mem_rd_en = (state_q == ST_FETCH) && (pend < 3'd2);
    mem_addr  = row_base_q + ADDR_W'(c_q);

    rd_eot          = '0;
    rd_eot[EOT_ROW] = (c_q == CW'(FEATURE_WIDTH - 1));
    rd_eot[EOT_WIN] = rd_eot[EOT_ROW] && (r_q == CW'(FEATURE_WIDTH - 1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_x_d    = '0;
          win_y_d    = '0;
          win_row_d  = '0;
          row_base_d = '0;
          r_d        = '0;
          c_d        = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_rd_en) begin
          if (rd_eot[EOT_ROW]) begin
            c_d = '0;
            if (rd_eot[EOT_WIN]) begin
              r_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              r_d        = r_q + CW'(1);
              row_base_d = row_base_q + ADDR_W'(IMG_W);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!infl_q && (skid_occ == 2'd0 || (skid_occ == 2'd1 && pop))) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (win_ack) begin
          if (int'(win_x_q) + STEP <= IMG_W - FEATURE_WIDTH) begin
            win_x_d    = XW'(int'(win_x_q) + STEP);
            row_base_d = win_row_q + ADDR_W'(int'(win_x_q) + STEP);
            state_d    = ST_FETCH;
          end else if (int'(win_y_q) + STEP <= IMG_H - FEATURE_WIDTH) begin
            win_x_d    = '0;
            win_y_d    = YW'(int'(win_y_q) + STEP);
            win_row_d  = win_row_q + ADDR_W'(STEP * IMG_W);
            row_base_d = win_row_d;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_x_q    <= '0;
      win_y_q    <= '0;
      win_row_q  <= '0;
      row_base_q <= '0;
      r_q        <= '0;
      c_q        <= '0;
      infl_q     <= 1'b0;
      eot_infl_q <= '0;
    end else begin
      state_q    <= state_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      win_row_q  <= win_row_d;
      row_base_q <= row_base_d;
      r_q        <= r_d;
      c_q        <= c_d;
      infl_q     <= mem_rd_en;
      eot_infl_q <= rd_eot;
    end
  end

  pix_skid #(.W(W_DATA + 2)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (infl_q),
    .in_dat  ({eot_infl_q, mem_rd_data}),
    .out_vld (dout_valid),
    .out_rdy (dout_ready),
    .out_dat ({dout_eot, dout_data}),
    .occ     (skid_occ)
  );

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign win_x = win_x_q;
  assign win_y = win_y_q;

`ifdef II_WIN_SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] win_cnt_q, win_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    win_cnt_d   = win_cnt_q;
    if (state_q == ST_IDLE && start) begin
      stall_cnt_d = '0;
      win_cnt_d   = '0;
    end else begin
      if (busy && dout_valid && !dout_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      if (state_q == ST_WAIT_ACK && win_ack && win_cnt_q != '1) win_cnt_d = win_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      win_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign win_cnt   = win_cnt_q;
`endif

endmodule

// File: tb/tb_ii_win_sched.sv
// Bench for ii_win_sched on an 8x8 image, 4x4 window, stride 2: scoreboard of expected
// pixels built from the scan rules, checked by an independent output monitor.
module tb_ii_win_sched;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int FW = 4;
  localparam int ST = 2;
  localparam int AW = 6;

  typedef struct {
    logic [7:0] dat;
    logic [1:0] eot;
    int         wx;
    int         wy;
  } px_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, mem_rd_en, dout_valid;
  logic          dout_ready = 1'b1;
  logic          win_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data = 8'd0;
  logic [7:0]    dout_data;
  logic [1:0]    dout_eot;
  logic [2:0]    win_x, win_y;
`ifdef II_WIN_SCHED_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   win_cnt;
`endif

  logic [7:0] ram [W*H];
  px_t        exp_q[$];
  px_t        e_m;
  int         errors = 0;
  int         checks = 0;
  int         pix_idx = 0;
  int         outstanding = 0;
  int         stall_exp = 0;
  int         done_cnt = 0;
  int         ack_delay = 3;
  int         low_left = 0;
  int         hx, hy;
  bit         rdy_rand = 1'b0;
  bit         low_arm = 1'b0;
  bit         prev_stall = 1'b0;
  bit         hs;
  logic [7:0] prev_dat;
  logic [1:0] prev_eot;

  ii_win_sched #(
    .W_DATA(8), .IMG_W(W), .IMG_H(H), .FEATURE_WIDTH(FW), .STEP(ST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_eot(dout_eot), .win_x(win_x), .win_y(win_y), .win_ack(win_ack)
`ifdef II_WIN_SCHED_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .win_cnt(win_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pixel RAM with one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  task automatic build_expected();
    for (int wy = 0; wy + FW <= H; wy += ST)
      for (int wx = 0; wx + FW <= W; wx += ST)
        for (int r = 0; r < FW; r++)
          for (int c = 0; c < FW; c++) begin
            px_t p;
            p.dat = ram[(wy + r) * W + wx + c];
            p.eot = {(r == FW - 1) && (c == FW - 1), c == FW - 1};
            p.wx  = wx;
            p.wy  = wy;
            exp_q.push_back(p);
          end
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      pix_idx     = 0;
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      hs = dout_valid && dout_ready;
      if (prev_stall) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout_data, prev_dat);
        chk("hold_eot", dout_eot, prev_eot);
      end
      if (mem_rd_en) chk("rd_outstanding_lt2", (outstanding - int'(hs)) < 2, 1);
      outstanding += int'(mem_rd_en) - int'(hs);
      if (busy && dout_valid && !dout_ready) stall_exp++;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", dout_data, -1);
        end else begin
          e_m = exp_q.pop_front();
          chk("pix_data", dout_data, e_m.dat);
          chk("pix_eot", dout_eot, e_m.eot);
          chk("pix_win_x", win_x, e_m.wx);
          chk("pix_win_y", win_y, e_m.wy);
        end
        if (win_x == 3'd2 && win_y == 3'd4 && pix_idx == 0) chk("win24_first", dout_data, 34);
        if (win_x == 3'd2 && win_y == 3'd4 && dout_eot == 2'b11) chk("win24_last", dout_data, 61);
        pix_idx = (dout_eot == 2'b11) ? 0 : pix_idx + 1;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dat   = dout_data;
      prev_eot   = dout_eot;
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      chk("done_busy_low", busy, 0);
    end
  end

  // Downstream classifier: acknowledge ack_delay cycles after each window's last pixel.
  always begin
    @(negedge clk);
    if (!rst && dout_valid && dout_ready && dout_eot == 2'b11) begin
      hx = int'(win_x);
      hy = int'(win_y);
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge clk);
        chk("wait_no_rd", mem_rd_en, 0);
        chk("wait_busy", busy, 1);
        chk("wait_win_x", win_x, hx);
        chk("wait_win_y", win_y, hy);
      end
      @(posedge clk); #1 win_ack = 1'b1;
      @(posedge clk); #1 win_ack = 1'b0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (low_arm && pix_idx == 5) begin
      low_arm  = 1'b0;
      low_left = 5;
    end
    if (low_left > 0) begin
      dout_ready = 1'b0;
      low_left--;
    end else if (rdy_rand) begin
      dout_ready = ($urandom_range(0, 99) < 30);
    end else begin
      dout_ready = 1'b1;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_eot"}, dout_eot, 0);
    chk({tag, "_win_x"}, win_x, 0);
    chk({tag, "_win_y"}, win_y, 0);
  endtask

  task automatic run_frame(input bit extra_start, input int bound);
    int n;
    build_expected();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    stall_exp = 0;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      if (extra_start && n == 40) start = 1'b1;
      if (extra_start && n == 41) start = 1'b0;
    end
    chk("frame_done_seen", done, 1);
    repeat (5) @(negedge clk);
    chk("done_pulse_count", done_cnt, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
`ifdef II_WIN_SCHED_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, stall_exp);
    chk("win_cnt", win_cnt, 9);
`endif
  endtask

  initial begin
    int n;
    for (int i = 0; i < W * H; i++) ram[i] = 8'(i % 256);
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full-rate scan.
    run_frame(1'b0, 3000);
    // 30% ready duty plus an ignored start while busy.
    rdy_rand = 1'b1;
    run_frame(1'b1, 20000);
    rdy_rand = 1'b0;
    // Acknowledge withheld for 100 cycles on every window.
    ack_delay = 100;
    run_frame(1'b0, 5000);
    ack_delay = 3;

    // Reset in the middle of the first window.
    build_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (pix_idx != 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_pixel7", pix_idx, 7);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 chk_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);

    // Replay from (0,0) with exactly five ready-low cycles mid-window.
    low_arm = 1'b1;
    run_frame(1'b0, 3000);
`ifdef II_WIN_SCHED_PERF_CNT_EN
    chk("stall_cnt_five", stall_cnt, 5);
`endif
    chk("low_cycles_used", low_arm, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ii_win_sched.md
Name: ii_win_sched

Overview:
- Scan scheduler that feeds the integral / squared-integral generator.
- Walks a FEATURE_WIDTH x FEATURE_WIDTH window across an image held in pixel RAM, left-to-right then top-to-bottom, with stride STEP.
- For each window it reads pixels row-major and emits them as a valid/ready stream with 2-bit eot framing.
- Waits for a per-window acknowledge from the downstream classifier before starting the next window.

Parameters:
- W_DATA, 8, pixel width
- IMG_W, 48, image width in pixels
- IMG_H, 48, image height in pixels
- FEATURE_WIDTH, 24, window side length
- STEP, 1, window stride in pixels, both axes
- ADDR_W, $clog2(IMG_W*IMG_H), pixel RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame scan when idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last window is acknowledged
- mem_rd_en  out  1  pixel RAM read strobe
- mem_addr  out  ADDR_W  pixel RAM read address
- mem_rd_data  in  W_DATA  read data, valid exactly 1 cycle after mem_rd_en
- dout_valid  out  1  pixel stream valid
- dout_ready  in  1  pixel stream ready
- dout_data  out  W_DATA  pixel
- dout_eot  out  2  bit0 = last pixel of window row; bit1 = last pixel of window
- win_x  out  $clog2(IMG_W)  x origin of the current window
- win_y  out  $clog2(IMG_H)  y origin of the current window
- win_ack  in  1  downstream finished the current window

Behaviour:
- Clocking/reset: single clock clk; rst is synchronous and active-high.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, dout_valid=0, dout_eot=0, win_x=0, win_y=0, FSM=IDLE, skid buffer empty.
- FSM states:
  - IDLE: start -> load win_x=0, win_y=0 -> FETCH. start is ignored in all other states.
  - FETCH: issue reads with row counter r and column counter c (0..FEATURE_WIDTH-1), addr = row_base + c, where row_base = (win_y+r)*IMG_W + win_x. row_base is updated incrementally (+IMG_W per row); no runtime multiplier. After issuing the last read (r=c=FEATURE_WIDTH-1) -> DRAIN.
  - DRAIN: wait until the skid buffer is empty and the final pixel has handshaken -> WAIT_ACK.
  - WAIT_ACK: on win_ack, advance the window position:
    - if win_x+STEP <= IMG_W-FEATURE_WIDTH: win_x += STEP -> FETCH
    - else if win_y+STEP <= IMG_H-FEATURE_WIDTH: win_x=0, win_y += STEP -> FETCH
    - else -> DONE
  - DONE: done=1 for one cycle -> IDLE; busy drops in the same cycle.
- win_ack is ignored outside WAIT_ACK. win_ack arriving in the same cycle the state is entered is honoured.
- Read flow control: mem_rd_en is asserted only when (skid occupancy + reads in flight) < 2. A read issued at cycle t lands in the skid buffer at t+1.
- Throughput: with dout_ready held high, one pixel per cycle, no bubbles inside a window.
- Latency: first dout_valid 2 cycles after entering FETCH.
- Stream output: dout_valid/dout_data/dout_eot are driven from the skid buffer head and stay stable while valid && !ready.
- eot tagging: eot bits travel with the data. Bit0 is set when c=FEATURE_WIDTH-1. Bit1 is set when additionally r=FEATURE_WIDTH-1, so the final pixel carries 2'b11.
- Boundary cases:
  - FEATURE_WIDTH=IMG_W=IMG_H gives exactly one window.
  - A stride that overshoots the image edge skips the partial window; windows never exceed the image.
  - Skid full with a read in flight cannot occur, by the flow-control rule above.
- Reset mid-frame: everything returns to reset values the next cycle, and any in-flight read data is discarded.
- Elaboration checks: FEATURE_WIDTH <= IMG_W and FEATURE_WIDTH <= IMG_H, STEP >= 1.

Optional Feature:
- Macro: II_WIN_SCHED_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cnt[31:0]: counts cycles with dout_valid && !dout_ready while busy.
  - win_cnt[15:0]: counts acknowledged windows.
- Both counters clear on an accepted start and on rst, and saturate rather than wrap.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package ii_sched_pkg:
  - state enum typedef (IDLE, FETCH, DRAIN, WAIT_ACK, DONE)
  - eot bit-position constants EOT_ROW=0, EOT_WIN=1
  - windows-per-row/column constant functions
- One sub-module, pix_skid: 2-entry valid/ready skid FIFO carrying {eot, data}, exposing occupancy.

Test Plan:
1. IMG 8x8, FW=4, STEP=2, dout_ready=1, win_ack pulsed 3 cycles after each window's eot=11 -> 9 windows in the order (0,0),(2,0),(4,0),(0,2)...(4,4); 16 pixels each; eot=01 on pixels 3, 7, 11 and eot=11 on pixel 15; done pulses once.
2. RAM preloaded with addr mod 256, window (2,4) -> first pixel 34, row pixels 34..37, last pixel 61.
3. Random dout_ready at 30% duty -> pixel sequence identical to scenario 1, no drops or duplicates, data/eot held stable while stalled; mem_rd_en never issued with 2 entries outstanding.
4. win_ack withheld for 100 cycles -> no further mem_rd_en, win_x/win_y held, busy=1.
5. rst asserted mid-window (pixel 7 of 16) -> next cycle all outputs at reset values; a new start replays from window (0,0).
6. II_WIN_SCHED_PERF_CNT_EN defined, dout_ready low for exactly 5 cycles during a full scan -> stall_cnt=5, win_cnt=9.
